store_narrow_unit: RTL and testbench
====================================

# store_narrow_unit

Store-side counterpart of the immediate/load extenders: takes a 32-bit register value from the MEM stage and narrows it to byte lanes for `sb`/`sh`/`sw`. It replicates and aligns the value, generates little-endian byte enables, and queues the write in a small FIFO. It drains to the data-memory write port through a valid/ready handshake, so a stalled memory does not stall the pipeline until the buffer fills.

## Interface
Parameters:
- `DEPTH`, 2 — FIFO entries; power of two, ≥2
- `AW`, 32 — address width

Ports:
- `clk`  in  1  — single clock, rising edge
- `rst_n`  in  1  — asynchronous active-low reset
- `st_valid`  in  1  — store request valid
- `st_ready`  out  1  — request accepted when `st_valid && st_ready`
- `st_addr`  in  AW  — byte address
- `st_data`  in  32  — register value; low byte/half used for narrow stores
- `st_size`  in  2  — 00 byte, 01 half, 10 word, 11 treated as word
- `flush`  in  1  — discard all queued, un-handshaked entries
- `mem_wvalid`  out  1  — head entry valid
- `mem_wready`  in  1  — memory accepts head
- `mem_waddr`  out  AW  — word address, bits [1:0] always 0
- `mem_wdata`  out  32  — lane-replicated data
- `mem_wbe`  out  4  — byte enables, bit i = lane [8i+7:8i]
- `buf_empty`  out  1  — FIFO empty
- `st_exc`  out  1  — one-cycle misaligned-store pulse (macro-gated)
- `st_exc_addr`  out  AW  — faulting address, held until next exception

## Operation
- Narrowing, computed at accept time and stored per entry:
  - byte: `wdata = {4{st_data[7:0]}}`, `wbe = 4'b0001 << st_addr[1:0]`
  - half: `wdata = {2{st_data[15:0]}}`, `wbe = st_addr[1] ? 4'b1100 : 4'b0011`
  - word: `wdata = st_data`, `wbe = 4'b1111`
- Stored address is `{st_addr[AW-1:2], 2'b00}`.
- FIFO control:
  - `st_ready = !full && !flush` (combinational).
  - No pass-through when full: a pop and a push attempt in the same cycle while full does not accept the push.
  - `mem_wvalid = !empty`. Head fields are stable while `mem_wvalid && !mem_wready`.
  - Pop on `mem_wvalid && mem_wready`. Push on the accept handshake. Simultaneous push and pop keeps the count unchanged.
  - Read and write pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit or a count.
- Flush:
  - The next edge empties the FIFO.
  - A head entry handshaked in the flush cycle is counted as written.
  - No request is accepted during flush.
- Misaligned store: half with `st_addr[0]=1`, or word with `st_addr[1:0]≠0`. Behaviour is set under Configuration.

## Timing
- Reset values: `mem_wvalid=0`, `mem_waddr=0`, `mem_wdata=0`, `mem_wbe=0`, `buf_empty=1`, `st_exc=0`, `st_exc_addr=0`, pointers 0. `st_ready=1` while in reset.
- Latency: a request accepted at edge t into an empty FIFO presents `mem_wvalid=1` from t+1.
- Throughput: 1 store/cycle when `mem_wready` stays high.
- `st_exc` is registered: high for the cycle after the accepting edge only.
- Reset asserted mid-drain drops all entries immediately (async). No write is issued after `rst_n` falls.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - A misaligned request is still handshaked (`st_ready` unaffected) but is not enqueued.
  - `st_exc` pulses and `st_exc_addr` captures the full `st_addr`.
- Undefined:
  - Address bits [0] (half) and [1:0] (word) are ignored, and the store is enqueued as aligned.
  - `st_exc` and `st_exc_addr` are tied to 0.

## Test plan
- `sb` at addr 0x1003, data 0xAABBCCDD, `mem_wready=1` -> the next cycle shows `mem_waddr=0x1000`, `mem_wdata=0xDDDDDDDD`, `mem_wbe=4'b1000`, then `buf_empty=1`.
- `sh` at 0x2002, data 0x12345678 -> `mem_wdata=0x56785678`, `mem_wbe=4'b1100`. `sw` at 0x2004 -> `mem_wbe=4'b1111`.
- `mem_wready=0`, DEPTH=2:
  - Push 3 stores back-to-back -> `st_ready` drops after 2 accepts, and the head stays stable.
  - Raise `mem_wready` -> the 2 writes are issued in order, then the third is accepted.
- Full FIFO with flush asserted in the same cycle as `mem_wready=1` -> exactly 1 write handshakes, then `buf_empty=1` and `mem_wvalid=0`.
- Misaligned `sw` at 0x3001:
  - With `STORE_MISALIGN_TRAP_EN`: `st_exc` pulses 1 cycle, `st_exc_addr=0x3001`, no memory write.
  - Without: a write to 0x3000 with `mem_wbe=4'b1111`.
- Deassert `rst_n` while `mem_wvalid=1` -> all outputs immediately take their reset values, and no write occurs after release.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: aligns sb/sh/sw data into byte lanes and queues writes in a FIFO.
// Optional misaligned-store trap enabled by defining STORE_MISALIGN_TRAP_EN.
module store_narrow_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    input  logic          flush,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wbe,
    output logic          buf_empty,
    output logic          st_exc,
    output logic [AW-1:0] st_exc_addr
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [3:0]    be_d   [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   nar_data;
    logic [3:0]    nar_be;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign st_ready   = !full && !flush;
    assign accept     = st_valid && st_ready;
    assign pop        = !empty && mem_wready;
    assign mem_wvalid = !empty;
    assign buf_empty  = empty;
    assign mem_waddr  = addr_q[rd_ptr_q];
    assign mem_wdata  = data_q[rd_ptr_q];
    assign mem_wbe    = be_q[rd_ptr_q];

    always_comb begin
        nar_data = st_data;
        nar_be   = 4'b1111;
        case (st_size)
            2'b00: begin
                nar_data = {4{st_data[7:0]}};
                nar_be   = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                nar_data = {2{st_data[15:0]}};
                nar_be   = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic          misalign;
    logic          st_exc_q, st_exc_d;
    logic [AW-1:0] st_exc_addr_q, st_exc_addr_d;

    // Misaligned requests complete the handshake but never reach the FIFO.
    assign misalign = ((st_size == 2'b01) && st_addr[0]) ||
                      (st_size[1] && (st_addr[1:0] != 2'b00));
    assign push     = accept && !misalign;

    always_comb begin
        st_exc_d      = accept && misalign;
        st_exc_addr_d = st_exc_d ? st_addr : st_exc_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_exc_q      <= 1'b0;
            st_exc_addr_q <= '0;
        end else begin
            st_exc_q      <= st_exc_d;
            st_exc_addr_q <= st_exc_addr_d;
        end
    end

    assign st_exc      = st_exc_q;
    assign st_exc_addr = st_exc_addr_q;
`else
    assign push        = accept;
    assign st_exc      = 1'b0;
    assign st_exc_addr = '0;
`endif

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Flush wins over everything; a head popped this cycle still counts as written.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                addr_d[wr_ptr_q] = {st_addr[AW-1:2], 2'b00};
                data_d[wr_ptr_q] = nar_data;
                be_d[wr_ptr_q]   = nar_be;
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit against a queue-based reference model.
// Define STORE_MISALIGN_TRAP_EN for both bench and RTL to check the trap build.
module tb_store_narrow_unit;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 32;
`ifdef STORE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [AW-1:0] st_addr = '0;
    logic [31:0]   st_data = '0;
    logic [1:0]    st_size = '0;
    logic          flush = 1'b0;
    logic          mem_wvalid;
    logic          mem_wready = 1'b0;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wbe;
    logic          buf_empty;
    logic          st_exc;
    logic [AW-1:0] st_exc_addr;

    store_narrow_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .flush(flush),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wbe(mem_wbe), .buf_empty(buf_empty),
        .st_exc(st_exc), .st_exc_addr(st_exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          dut_writes = 0;
    logic        exp_exc = 1'b0;
    logic [31:0] exp_exc_addr = '0;

    function automatic wr_t narrow(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        wr_t         w;
        int unsigned lane;
        lane   = a % 4;
        w.addr = a - lane;
        if (sz == 2'd0) begin
            w.data = (d & 32'hFF) * 32'h0101_0101;
            w.be   = 4'(1 << lane);
        end else if (sz == 2'd1) begin
            w.data = (d & 32'hFFFF) * 32'h0001_0001;
            w.be   = (lane >= 2) ? 4'hC : 4'h3;
        end else begin
            w.data = d;
            w.be   = 4'hF;
        end
        return w;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // One clock: drive inputs, compare DUT against model, advance model across the edge.
    task automatic run_cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic fl, input logic wr);
        logic exp_ready, acc, popd;
        st_valid = v; st_addr = a; st_data = d; st_size = sz; flush = fl; mem_wready = wr;
        #1;
        exp_ready = (q.size() < DEPTH) && !fl;
        n_cmp++;
        if (st_ready !== exp_ready) begin
            n_bad++; $display("FAIL st_ready: got %b expected %b", st_ready, exp_ready);
        end
        n_cmp++;
        if (mem_wvalid !== (q.size() != 0)) begin
            n_bad++; $display("FAIL mem_wvalid: got %b expected %b", mem_wvalid, q.size() != 0);
        end
        n_cmp++;
        if (buf_empty !== (q.size() == 0)) begin
            n_bad++; $display("FAIL buf_empty: got %b expected %b", buf_empty, q.size() == 0);
        end
        if (q.size() != 0) begin
            n_cmp++;
            if ({mem_waddr, mem_wdata, mem_wbe} !== q[0]) begin
                n_bad++;
                $display("FAIL head: got addr=%h data=%h be=%b expected addr=%h data=%h be=%b",
                         mem_waddr, mem_wdata, mem_wbe, q[0].addr, q[0].data, q[0].be);
            end
        end
        n_cmp++;
        if (st_exc !== exp_exc || st_exc_addr !== exp_exc_addr) begin
            n_bad++;
            $display("FAIL exc: got %b/%h expected %b/%h", st_exc, st_exc_addr, exp_exc, exp_exc_addr);
        end
        if (mem_wvalid === 1'b1 && wr) dut_writes++;
        acc  = v && exp_ready;
        popd = (q.size() != 0) && wr;
        @(posedge clk);
        if (popd) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc && !(TRAP && misaligned(a, sz))) q.push_back(narrow(a, d, sz));
        exp_exc = TRAP && acc && misaligned(a, sz);
        if (exp_exc) exp_exc_addr = a;
        #1;
    endtask

    task automatic test_reset();
        st_valid = 0; flush = 0; mem_wready = 0;
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({st_ready, mem_wvalid, buf_empty, st_exc} !== 4'b1010) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 1010", {st_ready, mem_wvalid, buf_empty, st_exc});
        end
        n_cmp++;
        if (mem_waddr !== '0 || mem_wdata !== '0 || mem_wbe !== '0 || st_exc_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %b %h expected zeros", mem_waddr, mem_wdata, mem_wbe, st_exc_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sb();
        run_cycle(1, 32'h1003, 32'hAABB_CCDD, 2'd0, 0, 1);
        n_cmp++;
        if (mem_waddr !== 32'h1000 || mem_wdata !== 32'hDDDD_DDDD || mem_wbe !== 4'b1000) begin
            n_bad++;
            $display("FAIL sb: got %h %h %b expected 00001000 dddddddd 1000", mem_waddr, mem_wdata, mem_wbe);
        end
        run_cycle(0, 0, 0, 2'd0, 0, 1);
        n_cmp++;
        if (buf_empty !== 1'b1) begin
            n_bad++; $display("FAIL sb_drain: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_sh_sw();
        run_cycle(1, 32'h2002, 32'h1234_5678, 2'd1, 0, 1);
        n_cmp++;
        if (mem_wdata !== 32'h5678_5678 || mem_wbe !== 4'b1100) begin
            n_bad++; $display("FAIL sh: got %h %b expected 56785678 1100", mem_wdata, mem_wbe);
        end
        run_cycle(1, 32'h2004, 32'h8765_4321, 2'd2, 0, 1);
        n_cmp++;
        if (mem_waddr !== 32'h2004 || mem_wdata !== 32'h8765_4321 || mem_wbe !== 4'b1111) begin
            n_bad++; $display("FAIL sw: got %h %h %b expected 00002004 87654321 1111", mem_waddr, mem_wdata, mem_wbe);
        end
        run_cycle(0, 0, 0, 2'd0, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] head;
        run_cycle(1, 32'h4000, 32'h1111_1111, 2'd2, 0, 0);
        run_cycle(1, 32'h4004, 32'h2222_2222, 2'd2, 0, 0);
        head = mem_wdata;
        n_cmp++;
        if (st_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_ready: got %b expected 0", st_ready);
        end
        run_cycle(1, 32'h4008, 32'h3333_3333, 2'd2, 0, 0);
        n_cmp++;
        if (mem_waddr !== 32'h4000 || mem_wdata !== head) begin
            n_bad++; $display("FAIL head_stable: got %h %h expected 00004000 %h", mem_waddr, mem_wdata, head);
        end
        run_cycle(1, 32'h4008, 32'h3333_3333, 2'd2, 0, 1);
        n_cmp++;
        if (mem_waddr !== 32'h4004) begin
            n_bad++; $display("FAIL order2: got %h expected 00004004", mem_waddr);
        end
        run_cycle(1, 32'h4008, 32'h3333_3333, 2'd2, 0, 1);
        n_cmp++;
        if (mem_waddr !== 32'h4008 || mem_wdata !== 32'h3333_3333) begin
            n_bad++; $display("FAIL third: got %h %h expected 00004008 33333333", mem_waddr, mem_wdata);
        end
        run_cycle(0, 0, 0, 2'd0, 0, 1);
    endtask

    task automatic test_flush();
        int w0;
        run_cycle(1, 32'h5000, 32'hA5A5_A5A5, 2'd2, 0, 0);
        run_cycle(1, 32'h5004, 32'h5A5A_5A5A, 2'd2, 0, 0);
        w0 = dut_writes;
        run_cycle(0, 0, 0, 2'd0, 1, 1);
        n_cmp++;
        if (dut_writes - w0 !== 1 || buf_empty !== 1'b1 || mem_wvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush: got writes=%0d empty=%b valid=%b expected 1 1 0", dut_writes - w0, buf_empty, mem_wvalid);
        end
        run_cycle(0, 0, 0, 2'd0, 0, 1);
    endtask

    task automatic test_misalign();
        run_cycle(1, 32'h3001, 32'hCAFE_F00D, 2'd2, 0, 1);
`ifdef STORE_MISALIGN_TRAP_EN
        n_cmp++;
        if (st_exc !== 1'b1 || st_exc_addr !== 32'h3001 || mem_wvalid !== 1'b0) begin
            n_bad++; $display("FAIL trap: got %b %h %b expected 1 00003001 0", st_exc, st_exc_addr, mem_wvalid);
        end
        run_cycle(0, 0, 0, 2'd0, 0, 1);
        n_cmp++;
        if (st_exc !== 1'b0 || st_exc_addr !== 32'h3001) begin
            n_bad++; $display("FAIL trap_pulse: got %b %h expected 0 00003001", st_exc, st_exc_addr);
        end
`else
        n_cmp++;
        if (mem_waddr !== 32'h3000 || mem_wbe !== 4'b1111 || st_exc !== 1'b0) begin
            n_bad++; $display("FAIL misalign_word: got %h %b %b expected 00003000 1111 0", mem_waddr, mem_wbe, st_exc);
        end
        run_cycle(0, 0, 0, 2'd0, 0, 1);
`endif
    endtask

    task automatic test_mid_reset();
        int w0;
        run_cycle(1, 32'h6000, 32'h0BAD_BEEF, 2'd2, 0, 0);
        run_cycle(1, 32'h6004, 32'h1234_ABCD, 2'd0, 0, 0);
        st_valid = 0; mem_wready = 1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({st_ready, mem_wvalid, buf_empty, st_exc} !== 4'b1010 ||
            mem_waddr !== '0 || mem_wdata !== '0 || mem_wbe !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b %h %h %b expected 1010 zeros",
                     {st_ready, mem_wvalid, buf_empty, st_exc}, mem_waddr, mem_wdata, mem_wbe);
        end
        q.delete(); exp_exc = 1'b0; exp_exc_addr = '0;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        w0 = dut_writes;
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 2'd0, 0, 1);
        n_cmp++;
        if (dut_writes !== w0) begin
            n_bad++; $display("FAIL post_reset_writes: got %0d expected 0", dut_writes - w0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 2'd0, 0, 1);
    endtask

    initial begin
        #1;
        test_reset();
        test_sb();
        test_sh_sw();
        test_back_to_back();
        test_flush();
        test_misalign();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
